id_ctrl_pipe: RTL
=================

Name: id_ctrl_pipe

Overview:
- Registered, handshaked main-control decoder for the ID stage of the MIPS core. It takes opcode/funct/rt from the IF/ID register and produces a registered control bundle for the ID/EX register.
- It adds three things a purely combinational decode does not have:
  - a valid/ready flow with backpressure;
  - a multi-cycle lockout for MULT/DIV;
  - an illegal-instruction trap state that holds until the pipeline is flushed.

Parameters:
- ALUOP_W, 4, width of alu_op field
- MULT_CYCLES, 4, busy cycles after MULT/MULTU issue (>=1)
- DIV_CYCLES, 32, busy cycles after DIV/DIVU issue (>=1)
- CNT_W, 6, lockout counter width; must satisfy 2**CNT_W > max(MULT_CYCLES,DIV_CYCLES)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  decoder accepts this cycle
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- rt  in  5  instr[20:16]
- flush  in  1  squash output, clear lockout/trap
- out_valid  out  1  ctrl bundle valid
- out_ready  in  1  ID/EX can take bundle
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne, jump, store_pc, lui_sig  out  1 each  registered control bits
- alu_op  out  ALUOP_W  0=add 1=sub 2=funct 3=or 4=and 5=slt
- md_busy  out  1  MULT/DIV lockout active
- illegal  out  1  bundle is an undecodable instruction

Behaviour:
- Reset, asynchronous: state=RUN, counter=0, every output register=0 (out_valid=0, illegal=0, md_busy=0, all control bits 0, alu_op=0).
- Accept when in_valid && in_ready.
  - in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
  - Decode is registered: the bundle appears with out_valid=1 the cycle after accept (latency 1).
  - The bundle holds stable while out_valid && !out_ready.
  - If out_ready with no new accept, out_valid goes to 0 the next cycle.
- Decode table:
  - R-type (op 0): reg_dst=1, reg_write=1, alu_op=2.
  - lw, lbu, lhu: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=0.
  - sw, sb, sh: alu_src=1, mem_write=1, alu_op=0.
  - beq: branch=1, alu_op=1.
  - bne: branch=1, branch_ne=1, alu_op=1.
  - j: jump=1.
  - jal: jump=1, reg_write=1, store_pc=1.
  - ori: alu_src=1, reg_write=1, alu_op=3.
  - andi: alu_src=1, reg_write=1, alu_op=4.
  - addi, addiu: alu_src=1, reg_write=1, alu_op=0.
  - slti, sltiu: alu_src=1, reg_write=1, alu_op=5.
  - lui: alu_src=1, reg_write=1, lui_sig=1.
  - Any other opcode: illegal=1, with all write/branch/jump bits forced to 0.
- States:
  - RUN: normal decode.
  - MD_WAIT: entered on accept of R-type with funct 0x18/0x19 (counter=MULT_CYCLES-1) or 0x1A/0x1B (counter=DIV_CYCLES-1). The MULT/DIV bundle itself is still emitted. In MD_WAIT, in_ready=0, md_busy=1, and the counter decrements each cycle. At counter==0 the next state is RUN. The MULT_CYCLES=1 case therefore gives exactly one lockout cycle.
  - TRAP: entered on accept of an illegal instruction. in_ready=0 until flush.
- flush has priority over everything:
  - next cycle out_valid=0, state=RUN, counter=0, md_busy=0;
  - no accept occurs in the flush cycle.
- flush during MD_WAIT or TRAP returns to RUN the next cycle.
- Reset mid-MD_WAIT clears immediately (asynchronous).

Optional Feature:
- REGIMM_EN defined: opcode 0x01 decodes bltz (rt=0) / bgez (rt=1) as branch=1, alu_op=5, with branch_ne=1 for bgez. Other rt values are illegal.
- REGIMM_EN undefined: opcode 0x01 is illegal and the rt port is unused.

Decomposition:
- Shared package (cpu_defs_pkg): opcode/funct localparams, ALU op codes, state enum {RUN, MD_WAIT, TRAP}, ctrl bundle struct.
- One natural sub-module: id_ctrl_decode, the pure combinational opcode/funct->bundle table. It is instantiated inside; the top holds the FSM, counter and output registers.

Test Plan:
- Reset then lw (op 0x23), out_ready=1 -> next cycle out_valid=1, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=0.
- bne accepted with out_ready=0 for 3 cycles -> bundle (branch=1, branch_ne=1, alu_op=1) held stable, in_ready=0 throughout; released on out_ready=1.
- DIV (op 0, funct 0x1A), DIV_CYCLES=32 -> md_busy=1 and in_ready=0 for exactly 32 cycles, then the next addiu is accepted.
- Opcode 0x3F -> illegal=1, reg_write=0, mem_write=0, in_ready stays 0 for 10 cycles; flush -> RUN, out_valid=0 next cycle.
- flush asserted in the same cycle as in_valid for ori -> no accept, out_valid=0 next cycle.
- REGIMM_EN: op 0x01, rt=1 -> branch=1, branch_ne=1, alu_op=5. Without REGIMM_EN -> illegal=1.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcodes, ALU op codes, ID-stage FSM states and the control bundle.
package cpu_defs_pkg;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [5:0] FN_DIV    = 6'h1a;
  localparam logic [5:0] FN_DIVU   = 6'h1b;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR, ALU_AND, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {RUN, MD_WAIT, TRAP} state_t;
  typedef struct packed {
    logic    illegal;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    store_pc;
    logic    lui_sig;
    alu_op_e alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_ctrl_decode.sv
// id_ctrl_decode: combinational opcode/funct to control-bundle table.
// REGIMM_EN enables bltz/bgez decode on opcode 0x01.
module id_ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output ctrl_t      ctrl,
  output logic       is_mult,
  output logic       is_div
);
`ifndef REGIMM_EN
  logic unused_rt;
  assign unused_rt = ^rt;
`endif
  assign is_mult = opcode == OP_RTYPE && (funct == FN_MULT || funct == FN_MULTU);
  assign is_div  = opcode == OP_RTYPE && (funct == FN_DIV || funct == FN_DIVU);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OP_LW, OP_LBU, OP_LHU: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW, OP_SB, OP_SH: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = opcode == OP_BNE;
        ctrl.alu_op    = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = opcode == OP_JAL;
        ctrl.store_pc  = opcode == OP_JAL;
      end
      OP_ORI, OP_ANDI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.lui_sig   = opcode == OP_LUI;
        ctrl.alu_op    = opcode == OP_ORI ? ALU_OR :
                         opcode == OP_ANDI ? ALU_AND :
                         (opcode == OP_SLTI || opcode == OP_SLTIU) ? ALU_SLT : ALU_ADD;
      end
`ifdef REGIMM_EN
      OP_REGIMM: begin
        ctrl.illegal   = rt > 5'd1;
        ctrl.branch    = rt <= 5'd1;
        ctrl.branch_ne = rt == 5'd1;
        ctrl.alu_op    = rt <= 5'd1 ? ALU_SLT : ALU_ADD;
      end
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: registered, handshaked ID-stage main control with MULT/DIV lockout and illegal trap.
// Optional REGIMM_EN macro enables bltz/bgez decode in the table.
module id_ctrl_pipe
  import cpu_defs_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               branch_ne,
  output logic               jump,
  output logic               store_pc,
  output logic               lui_sig,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               md_busy,
  output logic               illegal
);
  ctrl_t            dec;
  ctrl_t            ctrl_q;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_mult;
  logic             is_div;
  logic             accept;
  id_ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .rt      (rt),
    .ctrl    (dec),
    .is_mult (is_mult),
    .is_div  (is_div)
  );
  assign in_ready = state == RUN && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign md_busy  = state == MD_WAIT;
  assign {illegal, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
          branch, branch_ne, jump, store_pc, lui_sig} = ctrl_q[$bits(ctrl_t)-1:$bits(alu_op_e)];
  assign alu_op = ALUOP_W'(ctrl_q.alu_op);
  // The counter is loaded with N-1 so that MD_WAIT lasts exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (flush) begin
      state     <= RUN;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      ctrl_q    <= dec;
      out_valid <= 1'b1;
      state     <= dec.illegal ? TRAP : (is_mult || is_div) ? MD_WAIT : RUN;
      cnt       <= is_div ? CNT_W'(DIV_CYCLES - 1) : is_mult ? CNT_W'(MULT_CYCLES - 1) : '0;
    end else begin
      out_valid <= out_valid && !out_ready;
      if (state == MD_WAIT) begin
        state <= cnt == '0 ? RUN : MD_WAIT;
        cnt   <= cnt == '0 ? '0 : cnt - 1'b1;
      end
    end
  end
endmodule
